// File: rtl/square_pixel_datapath.sv
// rtl/square_pixel_datapath.sv - SIZE x SIZE pixel sweep datapath; SQUARE_BORDER_ONLY_EN plots only the perimeter
module square_pixel_datapath #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int DATA_W    = 7,
  parameter int COLOUR_W  = 3,
  parameter int SIZE_LOG2 = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_en,
  input  logic                ld_x,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                write_en,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                done
);

  localparam int CNT_W = 2 * SIZE_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t                state;
  logic [X_W-1:0]        x_reg;
  logic [Y_W-1:0]        y_reg;
  logic [COLOUR_W-1:0]   colour_reg;
  logic [CNT_W-1:0]      cnt;
  logic [SIZE_LOG2-1:0]  off_x;
  logic [SIZE_LOG2-1:0]  off_y;
  logic                  pixel_on;

  // Low bits of cnt are the X offset so the scan runs row-major.
  assign off_x = cnt[SIZE_LOG2-1:0];
  assign off_y = cnt[CNT_W-1:SIZE_LOG2];

`ifdef SQUARE_BORDER_ONLY_EN
  assign pixel_on = (off_x == '0) || (off_x == '1) || (off_y == '0) || (off_y == '1);
`else
  assign pixel_on = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      cnt        <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else if (load_en) begin
      // A load always aborts whatever sweep is in progress.
      if (ld_x) x_reg <= X_W'(data_in);
      else      y_reg <= Y_W'(data_in);
      colour_reg <= colour_in;
      state      <= S_IDLE;
      cnt        <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (write_en) begin
            state <= S_DRAW;
            cnt   <= '0;
          end
        end
        S_DRAW: begin
          if (write_en) begin
            x_out      <= x_reg + X_W'(off_x);
            y_out      <= y_reg + Y_W'(off_y);
            colour_out <= colour_reg;
            plot       <= pixel_on;
            cnt        <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_DONE;
          end else begin
            plot <= 1'b0;
          end
        end
        S_DONE: begin
          plot <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          plot  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_pixel_datapath.sv
// tb/tb_square_pixel_datapath.sv - bench for square_pixel_datapath (honours SQUARE_BORDER_ONLY_EN)
module tb_square_pixel_datapath;

  localparam int X_W = 8, Y_W = 7, DATA_W = 8, COLOUR_W = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic                load_en;
  logic                ld_x;
  logic [DATA_W-1:0]   data_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                write_en;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                done;

  square_pixel_datapath #(
    .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .COLOUR_W(COLOUR_W), .SIZE_LOG2(2)
  ) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .ld_x(ld_x),
    .data_in(data_in), .colour_in(colour_in), .write_en(write_en),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SQUARE_BORDER_ONLY_EN
  localparam int EXP_PLOTS = 12;
  localparam int EXP_INTERIOR_PLOT = 0;
`else
  localparam int EXP_PLOTS = 16;
  localparam int EXP_INTERIOR_PLOT = 1;
`endif

  // Reference: a sweep is "pixel n of 16"; pixel n sits at base + (n%4, n/4).
  int m_bx, m_by, m_c;
  bit m_active;
  int m_n;
  int e_x, e_y, e_c, e_plot, e_done;

  function automatic bit on_border(input int n);
`ifdef SQUARE_BORDER_ONLY_EN
    return (n % 4 == 0) || (n % 4 == 3) || (n / 4 == 0) || (n / 4 == 3);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_bx = 0; m_by = 0; m_c = 0; m_active = 0; m_n = 0;
      e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_done = 0;
    end else if (load_en) begin
      if (ld_x) m_bx = int'(data_in) % 256;
      else      m_by = int'(data_in) % 128;
      m_c = int'(colour_in);
      m_active = 0; m_n = 0; e_plot = 0; e_done = 0;
    end else if (!m_active) begin
      e_plot = 0; e_done = 0;
      if (write_en) begin m_active = 1; m_n = 0; end
    end else if (m_n == 16) begin
      e_plot = 0; e_done = 1;
    end else if (write_en) begin
      e_x = (m_bx + m_n % 4) % 256;
      e_y = (m_by + m_n / 4) % 128;
      e_c = m_c;
      e_plot = on_border(m_n);
      m_n++;
    end else begin
      e_plot = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("plot", int'(plot), e_plot);
      check("done", int'(done), e_done);
      check("x_out", int'(x_out), e_x);
      check("y_out", int'(y_out), e_y);
      check("colour_out", int'(colour_out), e_c);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input bit lx, input int d, input int c);
    load_en = 1; ld_x = lx; data_in = DATA_W'(d); colour_in = COLOUR_W'(c);
    tick();
    load_en = 0; ld_x = 1'($urandom); data_in = DATA_W'($urandom); colour_in = COLOUR_W'($urandom);
  endtask

  int cx[17], cy[17], cc[17], cp[17], cd[17];

  // Start a sweep and record the 17 cycles after the start edge.
  task automatic sweep;
    write_en = 1;
    tick();
    for (int i = 0; i < 17; i++) begin
      tick();
      cx[i] = int'(x_out); cy[i] = int'(y_out); cc[i] = int'(colour_out);
      cp[i] = int'(plot);  cd[i] = int'(done);
    end
  endtask

  initial begin
    int nplot;
    reset = 0; load_en = 1'($urandom); ld_x = 1'($urandom); write_en = 1'($urandom);
    data_in = DATA_W'($urandom); colour_in = COLOUR_W'($urandom);
    tick(); tick();
    chk_en = 1;
    check("reset_plot", int'(plot), 0);
    check("reset_done", int'(done), 0);
    check("reset_x", int'(x_out), 0);
    check("reset_y", int'(y_out), 0);
    check("reset_colour", int'(colour_out), 0);
    reset = 1; load_en = 0; write_en = 0;
    tick();

    // Basic filled/bordered draw.
    load(1, 10, 5); load(0, 20, 5);
    sweep();
    nplot = 0;
    for (int i = 0; i < 16; i++) nplot += cp[i];
    check("basic_plot_count", nplot, EXP_PLOTS);
    check("basic_p0_x", cx[0], 10);   check("basic_p0_y", cy[0], 20);
    check("basic_p3_x", cx[3], 13);   check("basic_p4_x", cx[4], 10);
    check("basic_p4_y", cy[4], 21);   check("basic_p15_x", cx[15], 13);
    check("basic_p15_y", cy[15], 23); check("basic_colour", cc[0], 5);
    check("basic_interior_plot", cp[5], EXP_INTERIOR_PLOT);
    check("basic_done_before", cd[15], 0);
    check("basic_plot_end", cp[16], 0);
    check("basic_done_end", cd[16], 1);
    for (int i = 0; i < 5; i++) tick();
    check("basic_done_sticky", int'(done), 1);
    write_en = 0;

    // Wrap-around on both axes.
    load(1, 254, 2); load(0, 126, 2);
    sweep();
    check("wrap_x0", cx[0], 254); check("wrap_x1", cx[1], 255);
    check("wrap_x2", cx[2], 0);   check("wrap_x3", cx[3], 1);
    check("wrap_y0", cy[0], 126); check("wrap_y1", cy[4], 127);
    check("wrap_y2", cy[8], 0);   check("wrap_y3", cy[12], 1);
    write_en = 0;

    // Abort at pixel 6 with a new X, then restart from offset (0,0).
    load(1, 40, 1); load(0, 50, 1);
    write_en = 1;
    for (int i = 0; i < 7; i++) tick();
    load_en = 1; ld_x = 1; data_in = 8'd77; colour_in = 3'd6;
    tick();
    load_en = 0;
    check("abort_plot", int'(plot), 0);
    check("abort_done", int'(done), 0);
    tick(); tick();
    check("abort_restart_x", int'(x_out), 77);
    check("abort_restart_y", int'(y_out), 50);
    check("abort_restart_colour", int'(colour_out), 6);
    write_en = 0;

    // Pause for 3 cycles after pixel 4.
    load(1, 3, 4); load(0, 9, 4);
    write_en = 1;
    tick();
    nplot = 0;
    for (int i = 0; i < 5; i++) begin tick(); nplot += int'(plot); end
    write_en = 0;
    for (int i = 0; i < 3; i++) begin tick(); check("pause_plot", int'(plot), 0); end
    write_en = 1;
    tick(); nplot += int'(plot);
    check("pause_resume_x", int'(x_out), 4);
    check("pause_resume_y", int'(y_out), 10);
    for (int i = 0; i < 10; i++) begin tick(); nplot += int'(plot); end
    check("pause_plot_total", nplot, EXP_PLOTS);
    tick();
    check("pause_done", int'(done), 1);
    write_en = 0;

    // Randomised traffic including mid-sweep resets.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) != 0);
      load_en   = ($urandom_range(0, 24) == 0);
      ld_x      = 1'($urandom);
      data_in   = DATA_W'($urandom);
      colour_in = COLOUR_W'($urandom);
      write_en  = ($urandom_range(0, 9) < 8);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
